// File: rtl/orao_loader.sv
// orao_loader: ioctl file download sequencer and CPU/loader memory write port arbiter.
// Define ORAO_LOADER_PTR_EN to store load_end into the BASIC end-of-program pointer after a load.
module orao_loader #(
    parameter logic [7:0]  LOAD_INDEX = 8'h01,
    parameter logic [15:0] RAM_TOP    = 16'h7FFF
`ifdef ORAO_LOADER_PTR_EN
    , parameter logic [15:0] PTR_ADDR = 16'h00E0
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_1m,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        cpu_halt,
    output logic        busy,
    output logic [15:0] load_start,
    output logic [15:0] load_end,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, SYNC, HDR_LO, HDR_HI, DATA, PTR_LO, PTR_HI, RELEASE} state_t;
    state_t state, state_nx;
    logic        buf_v, wr_q, loading, take, done, own, ptr_we;
    logic [7:0]  buf_d, byte_d, hdr_lo, wr_d, ptr_d;
    logic [1:0]  buf_c, live_c, byte_c;
    logic [15:0] cursor, wr_a, ptr_a;
`ifdef ORAO_LOADER_PTR_EN
    logic        has_data;
`endif

    // Byte classification (0 = header low, 1 = header high, 2 = payload) and buffer-first byte selection
    always_comb begin
        live_c   = (ioctl_addr == 27'd0) ? 2'd0 : (ioctl_addr == 27'd1) ? 2'd1 : 2'd2;
        loading  = (state == HDR_LO) || (state == HDR_HI) || (state == DATA);
        take     = loading && (buf_v || ioctl_wr);
        done     = loading && !ioctl_download && !buf_v && !ioctl_wr;
        byte_d   = buf_v ? buf_d : ioctl_dout;
        byte_c   = buf_v ? buf_c : live_c;
        own      = (state != IDLE) && (state != SYNC);
        cpu_halt = (state != IDLE) && (state != RELEASE);
        busy     = cpu_halt;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (ioctl_download && ioctl_index == LOAD_INDEX) ? SYNC : IDLE;
            SYNC:    state_nx = ce_1m ? HDR_LO : SYNC;
            HDR_LO:  state_nx = done ? RELEASE : (take && byte_c == 2'd0) ? HDR_HI : HDR_LO;
            HDR_HI:  state_nx = done ? RELEASE : (take && byte_c == 2'd1) ? DATA : HDR_HI;
`ifdef ORAO_LOADER_PTR_EN
            DATA:    state_nx = done ? (has_data ? PTR_LO : RELEASE) : DATA;
`else
            DATA:    state_nx = done ? RELEASE : DATA;
`endif
            PTR_LO:  state_nx = PTR_HI;
            PTR_HI:  state_nx = RELEASE;
            default: state_nx = IDLE;
        endcase
    end

    // Pointer write cycles that follow the payload
    always_comb begin
`ifdef ORAO_LOADER_PTR_EN
        ptr_we = (state == PTR_LO) || (state == PTR_HI);
        ptr_a  = (state == PTR_LO) ? PTR_ADDR : PTR_ADDR + 16'd1;
        ptr_d  = (state == PTR_LO) ? load_end[7:0] : load_end[15:8];
`else
        ptr_we = 1'b0;
        ptr_a  = 16'h0000;
        ptr_d  = 8'h00;
`endif
    end

    // Memory port mux: CPU passthrough unless the loader owns the port
    always_comb begin
        mem_addr = own ? (ptr_we ? ptr_a : wr_a) : cpu_addr;
        mem_din  = own ? (ptr_we ? ptr_d : wr_d) : cpu_dout;
        mem_we   = own ? (wr_q || ptr_we) : cpu_we;
    end

    // State register, holding buffer, header capture and registered payload writes
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            buf_v      <= 1'b0;
            wr_q       <= 1'b0;
            err        <= 1'b0;
            load_start <= 16'h0000;
            load_end   <= 16'h0000;
        end else begin
            state <= state_nx;
            wr_q  <= 1'b0;
            if (state == IDLE && state_nx == SYNC) err <= 1'b0;
            if (state == SYNC && ioctl_wr && buf_v) err <= 1'b1;
            if ((state == SYNC && ioctl_wr && !buf_v) || (loading && buf_v && ioctl_wr)) begin
                buf_d <= ioctl_dout;
                buf_c <= live_c;
            end
            if (state == SYNC && ioctl_wr) buf_v <= 1'b1;
            else if (loading) buf_v <= buf_v && ioctl_wr;
            if (take && state == HDR_LO && byte_c == 2'd0) hdr_lo <= byte_d;
            if (take && state == HDR_HI && byte_c == 2'd1) begin
                load_start <= {byte_d, hdr_lo};
                cursor     <= {byte_d, hdr_lo};
            end
            if (take && state == DATA && byte_c == 2'd2) begin
                wr_q     <= cursor <= RAM_TOP;
                wr_a     <= cursor;
                wr_d     <= byte_d;
                cursor   <= cursor + 16'd1;
                load_end <= cursor + 16'd1;
                if (cursor > RAM_TOP) err <= 1'b1;
            end
            if (done && state == HDR_HI) err <= 1'b1;
        end
    end

`ifdef ORAO_LOADER_PTR_EN
    // Tracks whether any payload byte arrived, gating the pointer update
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && state_nx == SYNC)) has_data <= 1'b0;
        else if (take && state == DATA && byte_c == 2'd2) has_data <= 1'b1;
    end
`endif
endmodule
